mod_m_univ_counter: RTL

Parametrised universal counter that generalises the free-running binary counter. Adds a programmable modulus, up/down direction, count enable, synchronous clear and parallel load. Provides terminal-count flags and a registered wrap pulse. Used as a timebase, divider and event counter in the same datapaths as the free-running counter.

---
 rtl/mod_m_univ_counter.sv | 95 +++++++++
 1 files changed

// File: rtl/mod_m_univ_counter.sv
// mod_m_univ_counter: N-bit counter with modulus M, up/down direction,
// count enable, synchronous clear, clamped parallel load, terminal-count
// decodes and a registered one-cycle wrap pulse.
//
// Optional build macro MOD_M_UNIV_COUNTER_SAT_EN: when defined, the counter
// saturates at the limit of the current direction instead of wrapping, and
// wrap pulses after each blocked step.
module mod_m_univ_counter #(
    parameter int N = 8,
    parameter int M = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         min_tick,
    output logic         wrap
);

    // Number of representable codes; used only for the legality check.
    localparam longint RANGE = longint'(1) << N;

    generate
        if (N < 2 || N > 62 || M < 2 || longint'(M) > RANGE) begin : g_bad_param
            $error("mod_m_univ_counter: illegal parameters N=%0d M=%0d", N, M);
        end
    endgenerate

    // Terminal value and unit step, sized to the counter width. The wrap
    // target is an explicit compare against Q_MAX, so M = 2**N needs no
    // reliance on natural overflow.
    localparam logic [N-1:0] Q_MAX  = N'(M - 1);
    localparam logic [N-1:0] Q_ZERO = '0;
    localparam logic [N-1:0] ONE    = N'(1);

    logic [N-1:0] q_reg;
    logic [N-1:0] q_next;
    logic         wrap_reg;
    logic         wrap_next;
    logic         at_top;
    logic         at_bot;
    logic         at_limit;
    logic [N-1:0] load_val;

    assign at_top   = (q_reg == Q_MAX);
    assign at_bot   = (q_reg == Q_ZERO);
    // Limit in the direction requested on this edge only.
    assign at_limit = up ? at_top : at_bot;
    // Out-of-range load values clamp to the top of the count range.
    assign load_val = (d > Q_MAX) ? Q_MAX : d;

    // Next-state selection: syn_clr > load > en > hold (reset handled in the register).
    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;
        if (syn_clr) begin
            q_next = Q_ZERO;
        end else if (load) begin
            q_next = load_val;
        end else if (en) begin
            if (at_limit) begin
                wrap_next = 1'b1;
`ifdef MOD_M_UNIV_COUNTER_SAT_EN
                q_next = q_reg;
`else
                q_next = up ? Q_ZERO : Q_MAX;
`endif
            end else begin
                q_next = up ? (q_reg + ONE) : (q_reg - ONE);
            end
        end
    end

    // Count and wrap-pulse registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg    <= Q_ZERO;
            wrap_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
        end
    end

    assign q        = q_reg;
    assign wrap     = wrap_reg;
    assign max_tick = at_top;
    assign min_tick = at_bot;

endmodule
